// File: rtl/sobel_pkg.sv
// Shared types for the Sobel scan controller.
// FSM state encoding and pixel coordinate width.
package sobel_pkg;

  localparam int COORD_W = 16;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sobel_scan_ctrl_line_buf.sv
// Two-row line buffer: one shared address, async read.
// A write shifts row1 into row0 and stores the new pixel in row1.
module sobel_line_buf #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int AW     = $clog2(IMG_W)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] row0_rd,
  output logic [DATA_W-1:0] row1_rd
);

  logic [DATA_W-1:0] row0_q [IMG_W];
  logic [DATA_W-1:0] row1_q [IMG_W];

  assign row0_rd = row0_q[addr];
  assign row1_rd = row1_q[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      row0_q[addr] <= row1_q[addr];
      row1_q[addr] <= din;
    end
  end

endmodule

// File: rtl/sobel_scan_ctrl.sv
// Raster scan controller feeding 3x1 pixel columns to a Sobel unit.
// Tracks window validity, coordinates and frame sequencing.
module sobel_scan_ctrl
  import sobel_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_pix,
  output logic [3*DATA_W-1:0] pix_col,
  output logic                sobel_en,
  output logic                edge_valid,
  input  logic                edge_ready,
  output logic [COORD_W-1:0]  edge_x,
  output logic [COORD_W-1:0]  edge_y,
  output logic                frame_done
);

  localparam int     AW       = $clog2(IMG_W);
  localparam coord_t LAST_COL = coord_t'(IMG_W - 1);
  localparam coord_t LAST_ROW = coord_t'(IMG_H - 1);
  localparam coord_t ONE      = coord_t'(1);
  localparam coord_t TWO      = coord_t'(2);

  state_e state_q, state_d;
  coord_t col_q, col_d;
  coord_t row_q, row_d;
  coord_t ex_q, ex_d;
  coord_t ey_q, ey_d;
  logic   ev_q, ev_d;

  logic              accept;
  logic              last_col;
  logic [DATA_W-1:0] lb0_rd;
  logic [DATA_W-1:0] lb1_rd;

  // Back-pressure: a pending window blocks further pixels.
  assign in_ready = !rst
                  && (state_q == ST_FILL || state_q == ST_RUN)
                  && !(ev_q && !edge_ready);
  assign accept   = in_valid && in_ready;
  assign sobel_en = accept;
  assign last_col = (col_q == LAST_COL);

  assign pix_col    = {in_pix, lb1_rd, lb0_rd};
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_DONE);
  assign edge_valid = ev_q;
  assign edge_x     = ex_q;
  assign edge_y     = ey_q;

  sobel_line_buf #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W),
    .AW     (AW)
  ) u_lb (
    .clk     (clk),
    .we      (accept),
    .addr    (col_q[AW-1:0]),
    .din     (in_pix),
    .row0_rd (lb0_rd),
    .row1_rd (lb1_rd)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    ev_d    = ev_q;
    ex_d    = ex_q;
    ey_d    = ey_q;

    if (ev_q && edge_ready) begin
      ev_d = 1'b0;
    end

    if (accept) begin
      if (last_col) begin
        col_d = '0;
        row_d = row_q + ONE;
      end else begin
        col_d = col_q + ONE;
      end
      // Columns 0-1 of a row hold stale data from the previous row.
      if (row_q >= TWO && col_q >= TWO) begin
        ev_d = 1'b1;
        ex_d = col_q - ONE;
        ey_d = row_q - ONE;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FILL;
          col_d   = '0;
          row_d   = '0;
        end
      end
      ST_FILL: begin
        if (accept && last_col && row_q == ONE) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept && last_col && row_q == LAST_ROW) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      ev_q    <= 1'b0;
      ex_q    <= '0;
      ey_q    <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ev_q    <= ev_d;
      ex_q    <= ex_d;
      ey_q    <= ey_d;
    end
  end

endmodule

// File: tb/tb_sobel_scan_ctrl.sv
// Directed bench for sobel_scan_ctrl on an 8x4 frame.
// Pixel value = x + 8*y = raster index.
module tb_sobel_scan_ctrl;

  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_pix;
  logic [3*DW-1:0] pix_col;
  logic          sobel_en;
  logic          edge_valid;
  logic          edge_ready;
  logic [15:0]   edge_x;
  logic [15:0]   edge_y;
  logic          frame_done;

  sobel_scan_ctrl #(
    .DATA_W (DW),
    .IMG_W  (W),
    .IMG_H  (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pix     (in_pix),
    .pix_col    (pix_col),
    .sobel_en   (sobel_en),
    .edge_valid (edge_valid),
    .edge_ready (edge_ready),
    .edge_x     (edge_x),
    .edge_y     (edge_y),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  int cyc = 0;
  int acc_cnt, last_acc_cyc, fd_cnt, fd_cyc;
  int acc18_cyc, first_ev_cyc;
  int en_bad = 0, rst_bad = 0;
  int stall_seen = 0, stall_bad = 0;
  int resume_seen = 0, resume_bad = 0;
  logic [23:0] pc17, pc18;
  logic [15:0] fx, fy;
  int wx[$];
  int wy[$];
  bit stall_phase = 0;
  bit resume_phase = 0;

  always @(negedge clk) begin
    cyc++;
    if (sobel_en !== (in_valid && in_ready)) en_bad++;
    if (rst && (in_ready || sobel_en)) rst_bad++;
    if (in_valid && in_ready) begin
      if (acc_cnt == 17) pc17 = pix_col;
      if (acc_cnt == 18) begin
        pc18 = pix_col;
        acc18_cyc = cyc;
      end
      acc_cnt++;
      last_acc_cyc = cyc;
    end
    if (edge_valid && first_ev_cyc < 0) begin
      first_ev_cyc = cyc;
      fx = edge_x;
      fy = edge_y;
    end
    if (edge_valid && edge_ready) begin
      wx.push_back(int'(edge_x));
      wy.push_back(int'(edge_y));
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (stall_phase) begin
      stall_seen++;
      if (in_ready || sobel_en || !edge_valid
          || edge_x != 16'd1 || edge_y != 16'd1) stall_bad++;
    end
    if (resume_phase) begin
      resume_seen++;
      if (!(in_valid && in_ready)) resume_bad++;
    end
  end

  task automatic clear_stats();
    acc_cnt = 0;
    last_acc_cyc = -100;
    fd_cnt = 0;
    fd_cyc = -1;
    acc18_cyc = -100;
    first_ev_cyc = -1;
    pc17 = '0;
    pc18 = '0;
    fx = '0;
    fy = '0;
    wx.delete();
    wy.delete();
  endtask

  // mode: 0 plain, 1 stall, 2 start in RUN, 3 random valid, 4 reset abort
  task automatic run_frame(input int mode);
    int budget = 0;
    int st_left = 0;
    bit stalled = 0;
    bit resume_next = 0;
    bit pulsed = 0;
    bit done = 0;
    clear_stats();
    start = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    while (!done && budget < 400) begin
      budget++;
      if (fd_cnt > 0 && !edge_valid) begin
        done = 1;
      end else begin
        in_pix = 8'(acc_cnt);
        in_valid = (acc_cnt < NPIX)
                && (mode != 3 || $urandom_range(0, 1) == 1);
        edge_ready = 1'b1;
        start = 1'b0;
        stall_phase = 0;
        resume_phase = 0;
        if (mode == 1) begin
          if (acc_cnt == 19 && !stalled) begin
            st_left = 5;
            stalled = 1;
          end
          if (st_left > 0) begin
            edge_ready = 1'b0;
            stall_phase = 1;
            st_left--;
            if (st_left == 0) resume_next = 1;
          end else if (resume_next) begin
            resume_phase = 1;
            resume_next = 0;
          end
        end
        if (mode == 2 && acc_cnt == 20 && !pulsed) begin
          start = 1'b1;
          pulsed = 1;
        end
        if (mode == 4 && acc_cnt == 20) begin
          rst = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0;
          in_valid = 1'b0;
          @(negedge clk);
          chk("abort_busy", busy, 0);
          chk("abort_edge_valid", edge_valid, 0);
          chk("abort_in_ready", in_ready, 0);
          repeat (3) @(negedge clk);
          chk("abort_no_frame_done", fd_cnt, 0);
          done = 1;
        end else begin
          @(posedge clk); #1;
        end
      end
    end
    stall_phase = 0;
    resume_phase = 0;
    chk("frame_in_budget", budget < 400, 1);
  endtask

  task automatic check_frame(input string name);
    chk({name, "_accepts"}, acc_cnt, NPIX);
    chk({name, "_fd_count"}, fd_cnt, 1);
    chk({name, "_fd_delay"}, fd_cyc - last_acc_cyc, 1);
    chk({name, "_pc17"}, pc17, {8'd17, 8'd9, 8'd1});
    chk({name, "_pc18"}, pc18, {8'd18, 8'd10, 8'd2});
    chk({name, "_first_ev_delay"}, first_ev_cyc - acc18_cyc, 1);
    chk({name, "_first_x"}, fx, 1);
    chk({name, "_first_y"}, fy, 1);
    chk({name, "_nwin"}, wx.size(), 12);
    for (int i = 0; i < wx.size() && i < 12; i++) begin
      chk($sformatf("%s_win%0d_x", name, i), wx[i], (i % 6) + 1);
      chk($sformatf("%s_win%0d_y", name, i), wy[i], (i / 6) + 1);
    end
    @(negedge clk);
    chk({name, "_idle_busy"}, busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_pix = '0;
    edge_ready = 1'b1;
    clear_stats();
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_sobel_en", sobel_en, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_edge_valid", edge_valid, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_edge_x", edge_x, 0);
    chk("reset_edge_y", edge_y, 0);
    chk("idle_in_ready", in_ready, 0);
    @(posedge clk); #1;

    run_frame(0);
    check_frame("plain");

    run_frame(1);
    check_frame("stall");
    chk("stall_cycles", stall_seen, 5);
    chk("stall_holds", stall_bad, 0);
    chk("resume_cycles", resume_seen, 1);
    chk("resume_accept", resume_bad, 0);

    run_frame(2);
    check_frame("start_in_run");

    run_frame(4);
    @(posedge clk); #1;
    run_frame(0);
    check_frame("after_abort");

    run_frame(3);
    check_frame("random_valid");

    chk("sobel_en_eq_accept", en_bad, 0);
    chk("rst_blocks_ready", rst_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_scan_ctrl.md
SOBEL_SCAN_CTRL -- requirements
Module: sobel_scan_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_W, 8, pixel width in bits.
- IMG_W, 640, pixels per line, at least 3.
- IMG_H, 480, lines per frame, at least 3.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  frame start request.
- busy  out  1  high while the state is not IDLE.
- in_valid  in  1  pixel available.
- in_ready  out  1  pixel accepted when both in_valid and in_ready are high.
- in_pix  in  DATA_W  raster-order pixel.
- pix_col  out  3*DATA_W  3x1 column for the Sobel unit; slot0 = row r-2, slot1 = row r-1, slot2 = current row.
- sobel_en  out  1  shift enable for the Sobel unit.
- edge_valid  out  1  Sobel X/Y outputs currently hold a valid window.
- edge_ready  in  1  downstream consumes the window.
- edge_x  out  16  centre column of the valid window.
- edge_y  out  16  centre row of the valid window.
- frame_done  out  1  one-cycle pulse at the end of a frame.

Function
REQ-003 The FSM states SHALL be IDLE, FILL (rows 0-1), RUN (rows 2..IMG_H-1) and DONE.
REQ-004 FSM transitions SHALL be:
- IDLE to FILL when start=1.
- FILL to RUN on acceptance of the last pixel of row 1.
- RUN to DONE on acceptance of pixel (IMG_W-1, IMG_H-1).
- DONE to IDLE after exactly one cycle.
REQ-005 start SHALL be ignored in every state except IDLE.
REQ-006 in_ready SHALL equal (state is FILL or RUN) AND NOT (edge_valid AND NOT edge_ready).
REQ-007 An accept is defined as in_valid AND in_ready; sobel_en SHALL equal accept combinationally, and no other condition SHALL assert sobel_en.
REQ-008 On an accept, pix_col SHALL equal {in_pix, lb1[col], lb0[col]}, with slot2 in the MSBs. In the same cycle, lb0[col] SHALL be written with lb1[col] and lb1[col] with in_pix.
REQ-009 col SHALL increment on each accept and wrap from IMG_W-1 to 0. row SHALL increment on that wrap. Both SHALL clear on entry to FILL.
REQ-010 edge_valid SHALL be set in the cycle after an accept with row>=2 and col>=2. This masks the stale columns shifted in from the previous row.
REQ-011 edge_valid SHALL clear in the cycle after edge_valid AND edge_ready, unless a new qualifying accept occurs in that same cycle, in which case it SHALL stay set.
REQ-012 edge_x and edge_y SHALL be registered with edge_valid as col-1 and row-1 of the qualifying accept, and SHALL be held stable while edge_valid=1 and edge_ready=0.
REQ-013 Sustained throughput SHALL be one pixel per cycle when in_valid=1 and edge_ready=1.
REQ-014 frame_done SHALL be high only in DONE.
REQ-015 busy SHALL be low only in IDLE.
REQ-016 The final window SHALL still be presented after entering DONE and IDLE, and SHALL remain pending until edge_ready is asserted.
REQ-017 A new frame SHALL NOT accept pixels while a window is still pending.

Reset
REQ-018 When rst=1 at a clock edge, the following SHALL be set:
- state = IDLE
- col = 0, row = 0
- edge_valid = 0, frame_done = 0
- edge_x = 0, edge_y = 0
REQ-019 While rst=1, in_ready and sobel_en SHALL be 0.
REQ-020 Line-buffer contents SHALL NOT be cleared by reset; FILL masking makes stale contents harmless.
REQ-021 Reset mid-frame SHALL abort the frame with no frame_done pulse.

Structure
REQ-022 The state enum and the coordinate width (16) SHALL live in the shared package sobel_pkg.
REQ-023 The two line buffers SHALL be one sub-module, sobel_line_buf: IMG_W x DATA_W x 2 rows, with a single read/write address, combinational read and write-on-enable.
REQ-024 The Sobel arithmetic SHALL remain outside this block, connected via pix_col and sobel_en.

Verification (IMG_W=8, IMG_H=4, DATA_W=8)
REQ-025 Reset then start, with 32 pixels of value x+8y streamed and edge_ready=1 -> exactly 12 edge_valid cycles. Coordinates SHALL be (1..6,1) then (1..6,2). frame_done SHALL pulse once, one cycle after the 32nd accept.
REQ-026 Pixel 17 (x=1, y=2) accepted -> pix_col = {17, 9, 1}. Pixel 18 accepted -> pix_col = {18, 10, 2}, with edge_valid=1 the next cycle at (1,1).
REQ-027 edge_ready held 0 for 5 cycles after the first edge_valid -> in_ready=0 and sobel_en=0 throughout, and edge_x/edge_y hold (1,1). Streaming SHALL resume on the cycle edge_ready returns to 1.
REQ-028 start pulsed during RUN -> no effect. Pixel count and frame_done timing SHALL be unchanged.
REQ-029 rst asserted at pixel 20 -> next cycle state=IDLE, edge_valid=0, in_ready=0. Then start plus a full frame -> identical results to REQ-025.
REQ-030 in_valid toggled randomly at 50% -> same 12 windows with the same coordinates, and sobel_en pulses equal the accepts.
